// File: rtl/decode_execute_reg.sv
`default_nettype none
// ============================================================================
// Module   : decode_execute_reg
// Purpose  : Decode-to-execute pipeline register. Captures operands, control
//            and forwarding selects every cycle, inserts a NOP bubble on
//            stall, flush or an empty decode slot, and freezes on hold.
//            Optional macro DECODE_EXECUTE_PERF_EN adds saturating
//            stall/flush bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module decode_execute_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 6,
  parameter int ALU_CTRL_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      hold,
  input  logic                      valid_d,
  input  logic [DATA_WIDTH-1:0]     pc_d,
  input  logic [DATA_WIDTH-1:0]     pc_plus4_d,
  input  logic [DATA_WIDTH-1:0]     rd1_d,
  input  logic [DATA_WIDTH-1:0]     rd2_d,
  input  logic [DATA_WIDTH-1:0]     imm_d,
  input  logic [REG_ADDR_WIDTH-1:0] rd_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
  input  logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_d,
  input  logic                      reg_write_d,
  input  logic                      mem_write_d,
  input  logic                      lw_d,
  input  logic                      lui_d,
  input  logic [1:0]                result_src_d,
  input  logic [1:0]                alu_mux1_sel_d,
  input  logic [1:0]                alu_mux2_sel_d,
  input  logic                      mem_mux_d,
  input  logic                      exec_mux_d,
  output logic                      valid_e,
  output logic [DATA_WIDTH-1:0]     pc_e,
  output logic [DATA_WIDTH-1:0]     pc_plus4_e,
  output logic [DATA_WIDTH-1:0]     rd1_e,
  output logic [DATA_WIDTH-1:0]     rd2_e,
  output logic [DATA_WIDTH-1:0]     imm_e,
  output logic [REG_ADDR_WIDTH-1:0] rd_e,
  output logic [REG_ADDR_WIDTH-1:0] rs1_e,
  output logic [REG_ADDR_WIDTH-1:0] rs2_e,
  output logic [ALU_CTRL_WIDTH-1:0] alu_ctrl_e,
  output logic                      reg_write_e,
  output logic                      mem_write_e,
  output logic                      lw_e,
  output logic                      lui_e,
  output logic [1:0]                result_src_e,
  output logic [1:0]                alu_mux1_sel_e,
  output logic [1:0]                alu_mux2_sel_e,
  output logic                      mem_mux_e,
  output logic                      exec_mux_e,
`ifdef DECODE_EXECUTE_PERF_EN
  output logic [31:0]               stall_bubbles,
  output logic [31:0]               flush_bubbles,
`endif
  output logic                      bubble_e
);

  // Operand-B select value that makes the execute stage treat a slot as a NOP.
  localparam logic [1:0] c_NOP_ALU_MUX2 = 2'b01;

  // Edge classification: hold wins over everything, then any bubble source.
  logic w_advance;
  logic w_insert_nop;

  assign w_advance    = ~hold;
  assign w_insert_nop = stall | flush | ~valid_d;

  // Pipeline state.
  logic                      r_valid;
  logic [DATA_WIDTH-1:0]     r_pc;
  logic [DATA_WIDTH-1:0]     r_pc_plus4;
  logic [DATA_WIDTH-1:0]     r_rd1;
  logic [DATA_WIDTH-1:0]     r_rd2;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [REG_ADDR_WIDTH-1:0] r_rs1;
  logic [REG_ADDR_WIDTH-1:0] r_rs2;
  logic [ALU_CTRL_WIDTH-1:0] r_alu_ctrl;
  logic                      r_reg_write;
  logic                      r_mem_write;
  logic                      r_lw;
  logic                      r_lui;
  logic [1:0]                r_result_src;
  logic [1:0]                r_alu_mux1_sel;
  logic [1:0]                r_alu_mux2_sel;
  logic                      r_mem_mux;
  logic                      r_exec_mux;
  logic                      r_bubble;

  // Stage register: reset and bubble both load the NOP image (rd=0, lw=0) so
  // the hazard unit never sees a forwarding or load-use match from a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid        <= 1'b0;
      r_pc           <= '0;
      r_pc_plus4     <= '0;
      r_rd1          <= '0;
      r_rd2          <= '0;
      r_imm          <= '0;
      r_rd           <= '0;
      r_rs1          <= '0;
      r_rs2          <= '0;
      r_alu_ctrl     <= '0;
      r_reg_write    <= 1'b0;
      r_mem_write    <= 1'b0;
      r_lw           <= 1'b0;
      r_lui          <= 1'b0;
      r_result_src   <= '0;
      r_alu_mux1_sel <= '0;
      r_alu_mux2_sel <= c_NOP_ALU_MUX2;
      r_mem_mux      <= 1'b0;
      r_exec_mux     <= 1'b0;
      r_bubble       <= 1'b1;
    end else if (w_advance) begin
      if (w_insert_nop) begin
        r_valid        <= 1'b0;
        r_pc           <= '0;
        r_pc_plus4     <= '0;
        r_rd1          <= '0;
        r_rd2          <= '0;
        r_imm          <= '0;
        r_rd           <= '0;
        r_rs1          <= '0;
        r_rs2          <= '0;
        r_alu_ctrl     <= '0;
        r_reg_write    <= 1'b0;
        r_mem_write    <= 1'b0;
        r_lw           <= 1'b0;
        r_lui          <= 1'b0;
        r_result_src   <= '0;
        r_alu_mux1_sel <= '0;
        r_alu_mux2_sel <= c_NOP_ALU_MUX2;
        r_mem_mux      <= 1'b0;
        r_exec_mux     <= 1'b0;
        r_bubble       <= 1'b1;
      end else begin
        r_valid        <= 1'b1;
        r_pc           <= pc_d;
        r_pc_plus4     <= pc_plus4_d;
        r_rd1          <= rd1_d;
        r_rd2          <= rd2_d;
        r_imm          <= imm_d;
        r_rd           <= rd_d;
        r_rs1          <= rs1_d;
        r_rs2          <= rs2_d;
        r_alu_ctrl     <= alu_ctrl_d;
        r_reg_write    <= reg_write_d;
        r_mem_write    <= mem_write_d;
        r_lw           <= lw_d;
        r_lui          <= lui_d;
        r_result_src   <= result_src_d;
        r_alu_mux1_sel <= alu_mux1_sel_d;
        r_alu_mux2_sel <= alu_mux2_sel_d;
        r_mem_mux      <= mem_mux_d;
        r_exec_mux     <= exec_mux_d;
        r_bubble       <= 1'b0;
      end
    end
  end

  assign valid_e        = r_valid;
  assign pc_e           = r_pc;
  assign pc_plus4_e     = r_pc_plus4;
  assign rd1_e          = r_rd1;
  assign rd2_e          = r_rd2;
  assign imm_e          = r_imm;
  assign rd_e           = r_rd;
  assign rs1_e          = r_rs1;
  assign rs2_e          = r_rs2;
  assign alu_ctrl_e     = r_alu_ctrl;
  assign reg_write_e    = r_reg_write;
  assign mem_write_e    = r_mem_write;
  assign lw_e           = r_lw;
  assign lui_e          = r_lui;
  assign result_src_e   = r_result_src;
  assign alu_mux1_sel_e = r_alu_mux1_sel;
  assign alu_mux2_sel_e = r_alu_mux2_sel;
  assign mem_mux_e      = r_mem_mux;
  assign exec_mux_e     = r_exec_mux;
  assign bubble_e       = r_bubble;

`ifdef DECODE_EXECUTE_PERF_EN
  // A simultaneous stall and flush is one bubble attributed to the flush.
  logic        w_count_stall;
  logic        w_count_flush;
  logic [31:0] r_stall_bubbles;
  logic [31:0] r_flush_bubbles;

  assign w_count_stall = w_advance & stall & ~flush;
  assign w_count_flush = w_advance & flush;

  // Saturating bubble counters, frozen during hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_bubbles <= '0;
      r_flush_bubbles <= '0;
    end else begin
      if (w_count_stall && (r_stall_bubbles != 32'hFFFF_FFFF)) begin
        r_stall_bubbles <= r_stall_bubbles + 32'd1;
      end
      if (w_count_flush && (r_flush_bubbles != 32'hFFFF_FFFF)) begin
        r_flush_bubbles <= r_flush_bubbles + 32'd1;
      end
    end
  end

  assign stall_bubbles = r_stall_bubbles;
  assign flush_bubbles = r_flush_bubbles;
`endif

endmodule
`default_nettype wire

// File: doc/decode_execute_reg.md
Name: decode_execute_reg

Overview:
- Pipeline register between decode (control unit, hazard unit, register file) and execute.
- Captures decoded operands, control and forwarding selects every cycle.
- Inserts a bubble when the hazard unit stalls or the branch/jump unit flushes, and freezes on a downstream hold.
- Its rd_e and lw_e outputs feed back to the hazard unit as exec_rd and exec_lw.

Parameters:
DATA_WIDTH, 32, width of operand, immediate and PC fields
REG_ADDR_WIDTH, 6, width of rd/rs fields; matches hazard unit register-index width
ALU_CTRL_WIDTH, 4, width of ALU operation code

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  load-use stall from hazard unit; insert bubble
flush  in  1  branch/jump redirect from branch unit; insert bubble
hold  in  1  downstream memory not ready; freeze all contents
valid_d  in  1  decode slot holds a real instruction
pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d  in  DATA_WIDTH each  decode data fields
rd_d, rs1_d, rs2_d  in  REG_ADDR_WIDTH each  register indices (rd_d = hazard rd_out)
alu_ctrl_d  in  ALU_CTRL_WIDTH  ALU operation
reg_write_d, mem_write_d, lw_d, lui_d  in  1 each  control; lui_d = hazard mem_mux2
result_src_d  in  2  writeback select
alu_mux1_sel_d, alu_mux2_sel_d  in  2 each  ALU operand forwarding selects
mem_mux_d, exec_mux_d  in  1 each  store-data forwarding selects
*_e  out  same widths  registered copy of every *_d input above, including valid_e
bubble_e  out  1  execute slot holds an inserted bubble

Behaviour:
- Single register stage: latency 1 cycle from *_d to *_e.
- Asynchronous reset (rst_n low) takes effect immediately, independent of clk. Reset values:
  - all *_e = 0, except alu_mux2_sel_e = 2'b01 (canonical NOP encoding);
  - bubble_e = 1, valid_e = 0.
- Per-edge action, first match wins:
  1. hold = 1: every register keeps its value, including bubble_e. stall and flush are ignored that cycle.
  2. flush = 1 or stall = 1: load the NOP image:
     - valid_e, reg_write_e, mem_write_e, lw_e, lui_e = 0;
     - rd_e = 0;
     - alu_mux1_sel_e = 00, alu_mux2_sel_e = 01, mem_mux_e = exec_mux_e = 0;
     - data fields and rs fields = 0;
     - bubble_e = 1.
  3. valid_d = 0: same NOP image as rule 2 (bubble_e = 1).
  4. Otherwise capture all *_d fields; bubble_e = 0, valid_e = 1.
- Simultaneous stall and flush: a single bubble, classified as flush for counting purposes.
- A NOP image always has rd_e = 0 and lw_e = 0, so it can never trigger forwarding or another stall in the hazard unit.
- A stalled instruction is re-presented by upstream in the next cycle. This block stores no copy of it; the stall only prevents its entry.
- Reset asserted mid-stream discards the in-flight instruction. The first edge after release follows the normal priority rules.
- No combinational path from any input to any output.

Optional Feature:
- Macro: DECODE_EXECUTE_PERF_EN.
- When defined, adds two outputs:
  - stall_bubbles  out  32: count of edges with stall=1, flush=0, hold=0.
  - flush_bubbles  out  32: count of edges with flush=1, hold=0.
- Both counters reset to 0 on rst_n, saturate at 32'hFFFF_FFFF, and do not count during hold.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-cycle -> all *_e = 0 immediately, alu_mux2_sel_e=01, bubble_e=1; release with valid_d=1, rd_d=5 -> next edge rd_e=5, valid_e=1, bubble_e=0.
- Load-use: edge 1 captures lw x5 (lw_e=1, rd_e=5); stall=1 on edge 2 -> rd_e=0, lw_e=0, reg_write_e=0, bubble_e=1; edge 3 with stall=0 captures add x6,x5,x1 with alu_mux1_sel_d=11 -> alu_mux1_sel_e=11.
- Flush: add x7 captured with reg_write_e=1; flush=1 next edge -> reg_write_e=0, rd_e=0, mem_write_e=0; stall=1 and flush=1 together -> one bubble, flush_bubbles increments by 1, stall_bubbles unchanged.
- Hold: capture sw with rd2_d=32'hDEADBEEF, mem_mux_d=1; hold=1 for 3 cycles with stall=1 and flush=1 toggling -> rd2_e stays DEADBEEF, mem_mux_e stays 1, counters unchanged.
- Invalid slot: valid_d=0 with rd_d=9, reg_write_d=1 -> rd_e=0, reg_write_e=0, bubble_e=1, counters unchanged.
- Perf saturation (macro defined): force stall_bubbles to 32'hFFFF_FFFE, apply 3 stall edges -> stall_bubbles reads FFFF_FFFF and stays there.
